// File: rtl/pipe_pkg.sv
// Shared pipeline definitions for the ID-stage hazard/stall logic and the
// multiply/divide busy sequencer.
package pipe_pkg;

   localparam int T_W             = 5;
   localparam int RA_W            = 5;
   localparam int MD_CNT_W        = 4;
   localparam int MULT_CYCLES_DEF = 5;
   localparam int DIV_CYCLES_DEF  = 10;

   typedef enum logic [1:0] {
      MD_MULT  = 2'd0,
      MD_MULTU = 2'd1,
      MD_DIV   = 2'd2,
      MD_DIVU  = 2'd3
   } md_op_t;

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } md_state_t;

   function automatic logic md_is_div(input logic [1:0] op);
      return (op == MD_DIV) || (op == MD_DIVU);
   endfunction

endpackage

// File: rtl/hazard_stall_ctrl_if.sv
// Bundle of ID/EX/MEM hazard inputs and stall/MDU status outputs.
// master = pipeline side driving hazard info, slave = stall controller.
interface hazard_stall_ctrl_if
   import pipe_pkg::*;
#(
   parameter int CNT_W = 32
);

   logic                ifReGrf1_Id;
   logic                ifReGrf2_Id;
   logic [RA_W-1:0]     grfRa1_Id;
   logic [RA_W-1:0]     grfRa2_Id;
   logic [T_W-1:0]      tUseRs_Id;
   logic [T_W-1:0]      tUseRt_Id;
   logic                ifMd_Id;
   logic                ifWrGrf_Ex;
   logic [RA_W-1:0]     grfWa_Ex;
   logic [T_W-1:0]      tNew_Ex;
   logic                ifWrGrf_Mem;
   logic [RA_W-1:0]     grfWa_Mem;
   logic [T_W-1:0]      tNew_Mem;
   logic                mdStart_Ex;
   logic [1:0]          mdOp_Ex;
   logic                flush_Mem;
   logic                clrCnt;
   logic                ifStall;
   logic                mdBusy;
   logic [MD_CNT_W-1:0] mdCnt;
   logic                mdDone;
   logic [CNT_W-1:0]    stallCnt;

   modport master (
      output ifReGrf1_Id, ifReGrf2_Id, grfRa1_Id, grfRa2_Id, tUseRs_Id, tUseRt_Id,
             ifMd_Id, ifWrGrf_Ex, grfWa_Ex, tNew_Ex, ifWrGrf_Mem, grfWa_Mem,
             tNew_Mem, mdStart_Ex, mdOp_Ex, flush_Mem, clrCnt,
      input  ifStall, mdBusy, mdCnt, mdDone, stallCnt
   );

   modport slave (
      input  ifReGrf1_Id, ifReGrf2_Id, grfRa1_Id, grfRa2_Id, tUseRs_Id, tUseRt_Id,
             ifMd_Id, ifWrGrf_Ex, grfWa_Ex, tNew_Ex, ifWrGrf_Mem, grfWa_Mem,
             tNew_Mem, mdStart_Ex, mdOp_Ex, flush_Mem, clrCnt,
      output ifStall, mdBusy, mdCnt, mdDone, stallCnt
   );

endinterface

// File: rtl/md_busy_fsm.sv
// Multiply/divide busy sequencer: counts down the MDU latency after a start
// and pulses done in the first idle cycle afterwards.
module md_busy_fsm
   import pipe_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start_i,
   input  logic                flush_i,
   input  logic [1:0]          op_i,
   output logic                busy_o,
   output logic [MD_CNT_W-1:0] cnt_o,
   output logic                done_o
);

   localparam logic [MD_CNT_W-1:0] MULT_LOAD = MD_CNT_W'(MULT_CYCLES);
   localparam logic [MD_CNT_W-1:0] DIV_LOAD  = MD_CNT_W'(DIV_CYCLES);
   localparam logic [MD_CNT_W-1:0] CNT_ONE   = MD_CNT_W'(1);

   md_state_t           state_q;
   logic [MD_CNT_W-1:0] cnt_q;
   logic                busy_q;
   logic                done_q;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               // A flushed start belongs to a squashed instruction.
               if (start_i && !flush_i) begin
                  state_q <= BUSY;
                  busy_q  <= 1'b1;
                  cnt_q   <= md_is_div(op_i) ? DIV_LOAD : MULT_LOAD;
               end
            end
            BUSY: begin
               // Starts and flushes are ignored here; the op already committed.
               if (cnt_q == CNT_ONE) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  cnt_q   <= '0;
                  done_q  <= 1'b1;
               end else begin
                  cnt_q <= cnt_q - CNT_ONE;
               end
            end
            default: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
               cnt_q   <= '0;
            end
         endcase
      end
   end

   assign busy_o = busy_q;
   assign cnt_o  = cnt_q;
   assign done_o = done_q;

endmodule

// File: rtl/hazard_stall_ctrl.sv
// ID-stage stall generator: GRF tUse/tNew hazard compare, MDU busy interlock
// and a saturating stall-cycle counter.
module hazard_stall_ctrl
   import pipe_pkg::*;
#(
   parameter int MULT_CYCLES = MULT_CYCLES_DEF,
   parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
   parameter int CNT_W       = 32
) (
   input  logic                clk,
   input  logic                reset_n,
   hazard_stall_ctrl_if.slave  bus
);

   logic             hazRs;
   logic             hazRt;
   logic             mdHaz;
   logic             ifStall;
   logic             mdBusy;
   logic [CNT_W-1:0] stallCnt_q;
   logic [CNT_W-1:0] stallCnt_d;

   md_busy_fsm #(
      .MULT_CYCLES (MULT_CYCLES),
      .DIV_CYCLES  (DIV_CYCLES)
   ) u_md_busy_fsm (
      .clk     (clk),
      .reset_n (reset_n),
      .start_i (bus.mdStart_Ex),
      .flush_i (bus.flush_Mem),
      .op_i    (bus.mdOp_Ex),
      .busy_o  (mdBusy),
      .cnt_o   (bus.mdCnt),
      .done_o  (bus.mdDone)
   );

   // $0 is hardwired, so a match on it is never a real dependency.
   assign hazRs = bus.ifReGrf1_Id && (bus.grfRa1_Id != '0) &&
                  ((bus.ifWrGrf_Ex  && (bus.grfRa1_Id == bus.grfWa_Ex)  && (bus.tUseRs_Id < bus.tNew_Ex)) ||
                   (bus.ifWrGrf_Mem && (bus.grfRa1_Id == bus.grfWa_Mem) && (bus.tUseRs_Id < bus.tNew_Mem)));

   assign hazRt = bus.ifReGrf2_Id && (bus.grfRa2_Id != '0) &&
                  ((bus.ifWrGrf_Ex  && (bus.grfRa2_Id == bus.grfWa_Ex)  && (bus.tUseRt_Id < bus.tNew_Ex)) ||
                   (bus.ifWrGrf_Mem && (bus.grfRa2_Id == bus.grfWa_Mem) && (bus.tUseRt_Id < bus.tNew_Mem)));

   // The start cycle counts as busy so a HI/LO access right behind a mult waits.
   assign mdHaz   = bus.ifMd_Id && (mdBusy || bus.mdStart_Ex);
   assign ifStall = !bus.flush_Mem && (hazRs || hazRt || mdHaz);

   always_comb begin
      stallCnt_d = stallCnt_q;
      if (bus.clrCnt) begin
         stallCnt_d = '0;
      end else if (ifStall && !(&stallCnt_q)) begin
         stallCnt_d = stallCnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         stallCnt_q <= '0;
      end else begin
         stallCnt_q <= stallCnt_d;
      end
   end

   assign bus.ifStall  = ifStall;
   assign bus.mdBusy   = mdBusy;
   assign bus.stallCnt = stallCnt_q;

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed plus randomized bench for hazard_stall_ctrl against a cycle-level
// reference model of the stall rules, MDU latency and stall counter.
module tb_hazard_stall_ctrl;
   import pipe_pkg::*;

   localparam int CNT_W = 4;
   localparam int CMAX  = (1 << CNT_W) - 1;

   logic clk = 1'b0;
   logic reset_n = 1'b1;
   always #5 clk = ~clk;

   hazard_stall_ctrl_if #(.CNT_W(CNT_W)) bus ();

   hazard_stall_ctrl #(
      .MULT_CYCLES (5),
      .DIV_CYCLES  (10),
      .CNT_W       (CNT_W)
   ) dut (
      .clk     (clk),
      .reset_n (reset_n),
      .bus     (bus)
   );

   int nchk = 0;
   int nerr = 0;
   int m_rem = 0;   // remaining MDU busy cycles
   int m_cnt = 0;   // stall cycles counted
   bit m_done = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nchk++;
      assert (obs === exp) else begin
         nerr++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic bit src_haz(input bit re, input int ra, input int tuse);
      if (!re || ra == 0) return 1'b0;
      if (bus.ifWrGrf_Ex && ra == int'(bus.grfWa_Ex) && tuse < int'(bus.tNew_Ex)) return 1'b1;
      if (bus.ifWrGrf_Mem && ra == int'(bus.grfWa_Mem) && tuse < int'(bus.tNew_Mem)) return 1'b1;
      return 1'b0;
   endfunction

   function automatic bit exp_stall();
      if (bus.flush_Mem) return 1'b0;
      return src_haz(bus.ifReGrf1_Id, int'(bus.grfRa1_Id), int'(bus.tUseRs_Id)) ||
             src_haz(bus.ifReGrf2_Id, int'(bus.grfRa2_Id), int'(bus.tUseRt_Id)) ||
             (bus.ifMd_Id && (m_rem > 0 || bus.mdStart_Ex));
   endfunction

   task automatic model_edge();
      bit s;
      s = exp_stall();
      if (bus.clrCnt) m_cnt = 0;
      else if (s && m_cnt < CMAX) m_cnt++;
      if (m_rem > 0) begin
         m_rem--;
         m_done = (m_rem == 0);
      end else begin
         m_done = 1'b0;
         if (bus.mdStart_Ex && !bus.flush_Mem) m_rem = (int'(bus.mdOp_Ex) >= 2) ? 10 : 5;
      end
   endtask

   task automatic tick();
      #1 chk("ifStall", 32'(bus.ifStall), 32'(exp_stall()));
      @(posedge clk);
      model_edge();
      #1;
      chk("mdBusy",   32'(bus.mdBusy),   32'(m_rem > 0));
      chk("mdCnt",    32'(bus.mdCnt),    32'(m_rem));
      chk("mdDone",   32'(bus.mdDone),   32'(m_done));
      chk("stallCnt", 32'(bus.stallCnt), 32'(m_cnt));
   endtask

   task automatic clear_in();
      bus.ifReGrf1_Id = 1'b0; bus.ifReGrf2_Id = 1'b0;
      bus.grfRa1_Id   = 5'd0; bus.grfRa2_Id   = 5'd0;
      bus.tUseRs_Id   = 5'd0; bus.tUseRt_Id   = 5'd0;
      bus.ifMd_Id     = 1'b0;
      bus.ifWrGrf_Ex  = 1'b0; bus.grfWa_Ex  = 5'd0; bus.tNew_Ex  = 5'd0;
      bus.ifWrGrf_Mem = 1'b0; bus.grfWa_Mem = 5'd0; bus.tNew_Mem = 5'd0;
      bus.mdStart_Ex  = 1'b0; bus.mdOp_Ex   = 2'd0;
      bus.flush_Mem   = 1'b0; bus.clrCnt    = 1'b0;
   endtask

   task automatic do_reset();
      clear_in();
      reset_n = 1'b0;
      #1;
      chk("rst_mdBusy",   32'(bus.mdBusy),   32'd0);
      chk("rst_mdCnt",    32'(bus.mdCnt),    32'd0);
      chk("rst_mdDone",   32'(bus.mdDone),   32'd0);
      chk("rst_stallCnt", 32'(bus.stallCnt), 32'd0);
      m_rem = 0; m_cnt = 0; m_done = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      @(posedge clk);
      #1;
   endtask

   task automatic set_lw_hazard();
      bus.ifWrGrf_Ex = 1'b1; bus.grfWa_Ex = 5'd5; bus.tNew_Ex = 5'd2;
      bus.ifReGrf1_Id = 1'b1; bus.grfRa1_Id = 5'd5; bus.tUseRs_Id = 5'd1;
   endtask

   initial begin
      #2;
      do_reset();

      // EX load feeding an ID ALU op.
      set_lw_hazard();
      #1 chk("lw_stall", 32'(bus.ifStall), 32'd1);
      tick();
      bus.grfWa_Ex = 5'd0;
      #1 chk("lw_wa0_nostall", 32'(bus.ifStall), 32'd0);
      tick();

      // rt against a MEM producer, at and past the tUse/tNew boundary.
      clear_in();
      bus.ifReGrf2_Id = 1'b1; bus.grfRa2_Id = 5'd7; bus.tUseRt_Id = 5'd0;
      bus.ifWrGrf_Mem = 1'b1; bus.grfWa_Mem = 5'd7; bus.tNew_Mem = 5'd1;
      #1 chk("mem_rt_stall", 32'(bus.ifStall), 32'd1);
      tick();
      bus.tUseRt_Id = 5'd1;
      #1 chk("mem_rt_equal_nostall", 32'(bus.ifStall), 32'd0);
      tick();

      // mult with mfhi waiting in ID.
      clear_in();
      bus.ifMd_Id = 1'b1; bus.mdStart_Ex = 1'b1; bus.mdOp_Ex = 2'd0;
      #1 chk("mfhi_start_stall", 32'(bus.ifStall), 32'd1);
      tick();
      bus.mdStart_Ex = 1'b0;
      for (int i = 1; i <= 5; i++) begin
         chk("mult_busy", 32'(bus.mdBusy), 32'd1);
         #1 chk("mfhi_busy_stall", 32'(bus.ifStall), 32'd1);
         tick();
      end
      chk("mult_done", 32'(bus.mdDone), 32'd1);
      chk("mult_idle", 32'(bus.mdBusy), 32'd0);
      #1 chk("mfhi_issue", 32'(bus.ifStall), 32'd0);
      tick();

      // div, then asynchronous reset while mdCnt is 4.
      clear_in();
      bus.mdStart_Ex = 1'b1; bus.mdOp_Ex = 2'd2;
      tick();
      bus.mdStart_Ex = 1'b0;
      chk("div_load", 32'(bus.mdCnt), 32'd10);
      for (int k = 0; k < 20 && m_rem != 4; k++) tick();
      chk("div_cnt4", 32'(bus.mdCnt), 32'd4);
      do_reset();

      // flush kills a same-cycle start.
      bus.ifMd_Id = 1'b1; bus.mdStart_Ex = 1'b1; bus.mdOp_Ex = 2'd3; bus.flush_Mem = 1'b1;
      #1 chk("flush_nostall", 32'(bus.ifStall), 32'd0);
      tick();
      chk("flush_stays_idle", 32'(bus.mdBusy), 32'd0);

      // stall counter: count, clear with priority, saturate.
      clear_in();
      set_lw_hazard();
      repeat (7) tick();
      chk("cnt7", 32'(bus.stallCnt), 32'd7);
      bus.clrCnt = 1'b1;
      tick();
      chk("cnt_clr", 32'(bus.stallCnt), 32'd0);
      bus.clrCnt = 1'b0;
      repeat (20) tick();
      chk("cnt_sat", 32'(bus.stallCnt), 32'(CMAX));

      // randomized traffic
      for (int n = 0; n < 400; n++) begin
         bus.ifReGrf1_Id = 1'($urandom_range(0, 1));
         bus.ifReGrf2_Id = 1'($urandom_range(0, 1));
         bus.grfRa1_Id   = 5'($urandom_range(0, 3));
         bus.grfRa2_Id   = 5'($urandom_range(0, 3));
         bus.tUseRs_Id   = 5'($urandom_range(0, 3));
         bus.tUseRt_Id   = 5'($urandom_range(0, 3));
         bus.ifMd_Id     = ($urandom_range(0, 2) == 0);
         bus.ifWrGrf_Ex  = 1'($urandom_range(0, 1));
         bus.grfWa_Ex    = 5'($urandom_range(0, 3));
         bus.tNew_Ex     = 5'($urandom_range(0, 3));
         bus.ifWrGrf_Mem = 1'($urandom_range(0, 1));
         bus.grfWa_Mem   = 5'($urandom_range(0, 3));
         bus.tNew_Mem    = 5'($urandom_range(0, 3));
         bus.mdStart_Ex  = ($urandom_range(0, 3) == 0);
         bus.mdOp_Ex     = 2'($urandom_range(0, 3));
         bus.flush_Mem   = ($urandom_range(0, 7) == 0);
         bus.clrCnt      = ($urandom_range(0, 15) == 0);
         tick();
      end

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule

// File: doc/hazard_stall_ctrl.md
# hazard_stall_ctrl

Pipeline scheduler that produces the single `ifStall` control consumed by the ID/EX pipeline register (and the IF/ID hold). It resolves GRF read-after-write hazards by comparing ID-stage tUse against EX/MEM-stage tNew, and it sequences the multi-cycle multiply/divide unit with a busy FSM so HI/LO consumers wait in ID. It also keeps a saturating stall-cycle counter for performance checks. Sits beside the decoder in ID; inputs come from the ID, ID/EX and EX/MEM registers.

## Interface
- `MULT_CYCLES`, 5, busy cycles for mult/multu
- `DIV_CYCLES`, 10, busy cycles for div/divu
- `CNT_W`, 32, stall counter width
- `clk` in 1 pipeline clock
- `reset_n` in 1 asynchronous, active-low reset
- `ifReGrf1_Id`, `ifReGrf2_Id` in 1 ID instruction reads rs / rt
- `grfRa1_Id`, `grfRa2_Id` in 5 rs / rt addresses in ID
- `tUseRs_Id`, `tUseRt_Id` in 5 cycles until rs / rt is needed
- `ifMd_Id` in 1 ID instruction is mult/div/mfhi/mflo/mthi/mtlo
- `ifWrGrf_Ex`, `grfWa_Ex`, `tNew_Ex` in 1/5/5 EX producer: write enable, address, remaining cycles at EX
- `ifWrGrf_Mem`, `grfWa_Mem`, `tNew_Mem` in 1/5/5 MEM producer, same meaning
- `mdStart_Ex` in 1 EX holds a mult/div this cycle
- `mdOp_Ex` in 2 0 mult, 1 multu, 2 div, 3 divu
- `flush_Mem` in 1 exception/eret flush
- `clrCnt` in 1 synchronous clear of `stallCnt`
- `ifStall` out 1 stall ID, bubble into EX
- `mdBusy` out 1 registered, MDU busy
- `mdCnt` out 4 remaining busy cycles
- `mdDone` out 1 one-cycle pulse, result valid in HI/LO
- `stallCnt` out CNT_W stalled cycles since reset/clear

## Operation
- Data hazard per source s∈{rs,rt}: `hazS = ifReGrfS_Id & (RaS != 0) & ((ifWrGrf_Ex & RaS==grfWa_Ex & tUseS < tNew_Ex) | (ifWrGrf_Mem & RaS==grfWa_Mem & tUseS < tNew_Mem))`. `tNew_*` are remaining cycles at the current stage, unsigned compare.
- MD hazard: `ifMd_Id & (mdBusy | mdStart_Ex)`.
- `ifStall = ~flush_Mem & (hazRs | hazRt | mdHaz)`; combinational.
- FSM: IDLE, BUSY.
  - IDLE: `mdStart_Ex & ~flush_Mem` → BUSY, `mdCnt` ← MULT_CYCLES (op 0/1) or DIV_CYCLES (op 2/3).
  - BUSY: `mdCnt` decrements each cycle. At `mdCnt==1`: → IDLE, `mdCnt` ← 0, `mdDone` ← 1.
- `mdStart_Ex` in BUSY is ignored; stalling prevents it.
- `flush_Mem` in BUSY does not abort; the older instruction has committed.
- `mdDone` is high only in the first IDLE cycle after BUSY.
- `stallCnt` increments on every cycle with `ifStall=1` and saturates at all-ones. `clrCnt` has priority over increment.

## Timing
- Reset (`reset_n` low, any time, including mid-BUSY): state IDLE, `mdBusy`=0, `mdCnt`=0, `mdDone`=0, `stallCnt`=0. `ifStall` then follows inputs only.
- Start accepted at edge E0: `mdBusy`=1 for exactly N cycles after E0 (N = 5 or 10), then IDLE with `mdDone`=1 for one cycle.
- ID HI/LO instruction stalls from the start cycle through the last busy cycle. It proceeds in the `mdDone` cycle.
- Zero latency from hazard inputs to `ifStall`. `stallCnt` updates at the next edge.
- `flush_Mem` and `mdStart_Ex` in the same cycle: start rejected, `ifStall`=0.

## Structure
- Shared package `pipe_pkg`:
  - tUse/tNew width (5)
  - `mdOp` encoding
  - `md_state_t` {IDLE, BUSY}
  - default cycle counts
- Sub-module `md_busy_fsm`: state, `mdCnt`, `mdDone`.
- Top level holds the hazard comparators, the stall OR and `stallCnt`.

## Test plan
- EX lw to $5 (`tNew_Ex`=2), ID add reading $5 (`tUseRs`=1) → `ifStall`=1; same with `grfWa_Ex`=0 → `ifStall`=0.
- mult start (op 0) at cycle 0 → `mdBusy` 1 in cycles 1–5, `mdDone`=1 in cycle 6. mfhi in ID stalls cycles 0–5 and issues in cycle 6.
- div (op 2) → `mdCnt` 10,9,…,1 then 0. `reset_n` low at count 4 → immediately IDLE with `mdCnt`=0 and `mdBusy`=0.
- `mdStart_Ex` with `flush_Mem`=1 → stays IDLE; `ifStall`=0 although `ifMd_Id`=1.
- 7 stall cycles → `stallCnt`=7; `clrCnt` with stall → 0. `CNT_W`=4 run of 20 stalls → saturates at 15.
